// File: rtl/feature_output.sv
// feature_output: collects valid-window convolution results, shifts and clamps them to 8 bits,
// and emits them with a row-major feature-map address.
module feature_output #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 3,
   parameter int DATA_W = 20,
   parameter int SHIFT  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [7:0]        out_data,
   output logic [9:0]        out_addr,
   output logic              busy,
   output logic              done
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] CMIN = CW'(K - 1);
   localparam logic [RW-1:0] RMIN = RW'(K - 1);
   localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);

   typedef enum logic {IDLE, COLLECT} state_t;
   state_t state, state_n;

   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic [9:0]               addr_cnt;
   logic                     open, clear, accept, keep, last;
   logic signed [DATA_W-1:0] y;
   logic [7:0]               sat;

   always_ff @(posedge clk)
      if (!rst) state <= IDLE;
      else      state <= state_n;

   // The done cycle is the last COLLECT cycle; a start there chains straight into a new frame.
   always_comb begin
      open    = (state == IDLE) || done;
      state_n = open ? (start ? COLLECT : IDLE) : state;
      clear   = open && start;
   end

   assign busy   = (state == COLLECT);
   assign accept = busy && in_valid && !done;
   assign keep   = accept && (col >= CMIN) && (row >= RMIN);
   assign last   = accept && (col == CMAX) && (row == RMAX);
   assign y      = $signed(in_data) >>> SHIFT;
   assign sat    = y[DATA_W-1] ? 8'd0 : (|y[DATA_W-2:8] ? 8'd255 : y[7:0]);

   always_ff @(posedge clk) begin
      if (!rst) begin
         col       <= '0;
         row       <= '0;
         addr_cnt  <= '0;
         out_addr  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         out_valid <= keep;
         done      <= last;
         if (clear) begin
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
         end else if (accept) begin
            col <= (col == CMAX) ? '0 : col + CW'(1);
            row <= (col == CMAX) ? ((row == RMAX) ? '0 : row + RW'(1)) : row;
         end
         if (keep) begin
            addr_cnt <= addr_cnt + 10'd1;
            out_addr <= addr_cnt;
            out_data <= sat;
         end
      end
   end
endmodule

// File: doc/feature_output.md
FEATURE_OUTPUT -- requirements
Module: feature_output

Interface
REQ-001 Parameter IMG_W, default 28, input image width in pixels.
REQ-002 Parameter IMG_H, default 28, input image height in pixels.
REQ-003 Parameter K, default 3, convolution kernel edge size.
REQ-004 Parameter DATA_W, default 20, width of the signed convolution result.
REQ-005 Parameter SHIFT, default 8, arithmetic right shift applied before saturation.
REQ-006 clk  input  1  the single clock; all logic on the rising edge.
REQ-007 rst  input  1  reset; synchronous and active-low.
REQ-008 start  input  1  one-cycle request to begin collecting one feature map.
REQ-009 in_valid  input  1  in_data carries one convolution result this cycle.
REQ-010 in_data  input  DATA_W  signed two's-complement convolution result, one per input pixel position, raster order.
REQ-011 out_valid  output  1  out_data/out_addr valid this cycle.
REQ-012 out_data  output  8  unsigned activated feature value.
REQ-013 out_addr  output  10  linear feature-map address, row-major, 0 .. (IMG_W-K+1)*(IMG_H-K+1)-1.
REQ-014 busy  output  1  high while in COLLECT state.
REQ-015 done  output  1  one-cycle pulse when the last feature value has been emitted.

Function
REQ-016 States SHALL be IDLE and COLLECT; the reset state is IDLE.
REQ-017 IDLE -> COLLECT on start=1; COLLECT -> IDLE in the cycle after the last kept sample is accepted; start is ignored in COLLECT.
REQ-018 On entering COLLECT, column counter col, row counter row, and out_addr counter SHALL be 0.
REQ-019 in_valid SHALL be ignored in IDLE; in COLLECT each cycle with in_valid=1 accepts one sample, and in_valid=0 stalls all counters (no output).
REQ-020 Each accepted sample is the window whose bottom-right corner is at (row, col); col increments per sample and wraps IMG_W-1 -> 0 with row+1.
REQ-021 A sample SHALL be kept iff col >= K-1 and row >= K-1; other samples are discarded with no output.
REQ-022 Kept value: y = in_data >>> SHIFT (arithmetic); out_data = 0 if y < 0, 255 if y > 255, else y[7:0].
REQ-023 Latency: out_valid, out_data, out_addr SHALL be registered, asserted the cycle after the accepted kept sample, for exactly one cycle.
REQ-024 out_addr SHALL increment by 1 per kept sample; with defaults the range is 0..675 (26x26 = 676 outputs).
REQ-025 Last kept sample is row=IMG_H-1, col=IMG_W-1; done SHALL pulse in the same cycle as its out_valid (out_addr=675 by default).
REQ-026 start asserted in the same cycle as done SHALL begin a new frame (counters cleared, busy stays high).
REQ-027 busy SHALL be 1 exactly while state=COLLECT.

Reset
REQ-028 With rst=0 at a clock edge: state=IDLE, col=row=0, out_addr=0, out_data=0, out_valid=0, busy=0, done=0.
REQ-029 Reset SHALL take priority over start and in_valid; reset mid-frame discards the partial frame and no done pulse is produced.

Verification
REQ-030 start, then 784 consecutive in_valid samples with in_data=0x00200 -> exactly 676 out_valid pulses, all out_data=2, out_addr 0..675 in order, done with addr 675, busy low the following cycle.
REQ-031 First kept sample: sample index 58 (row 2, col 2) -> first out_valid one cycle later with out_addr=0; samples 0..57 and cols 0..1 of every row produce no output.
REQ-032 Saturation: in_data=-1 -> out_data=0; in_data=0x1FF00 (positive, >255 after shift) -> 255; in_data=0x0FF00 -> 255; in_data=0x00100 -> 1.
REQ-033 in_valid toggled 1/0 randomly through a frame -> same 676 outputs and addresses as REQ-030, done only after the 784th accepted sample.
REQ-034 rst=0 after 300 samples, then start and a full frame -> no output during reset, new frame restarts at out_addr=0, exactly 676 outputs, single done.
REQ-035 start pulsed mid-frame and in_valid pulsed in IDLE -> both ignored; frame output unchanged, no outputs while IDLE.
